pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional skid entry, flush, bubble tagging
// and a saturating count of bubbles delivered downstream.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bubble,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bubble,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a held head stays unchanged
  // until it is consumed.

  logic              head_valid_q, head_valid_d;
  logic              head_bubble_q, head_bubble_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic              skid_bubble_q, skid_bubble_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic              accept;
  logic              deliver;
  logic [CTRL_W-1:0] in_ctrl_m;

  // With a skid entry, ready depends only on registered state so no
  // combinational path runs from out_ready back to in_ready.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = !skid_valid_q;
    end else begin : g_pass_ready
      assign in_ready = !head_valid_q || out_ready;
    end
  endgenerate

  assign accept    = in_valid && in_ready;
  assign deliver   = head_valid_q && out_ready;
  assign in_ctrl_m = in_bubble ? '0 : in_ctrl;

  always_comb begin
    head_valid_d  = head_valid_q;
    head_bubble_d = head_bubble_q;
    head_ctrl_d   = head_ctrl_q;
    head_data_d   = head_data_q;
    skid_valid_d  = skid_valid_q;
    skid_bubble_d = skid_bubble_q;
    skid_ctrl_d   = skid_ctrl_q;
    skid_data_d   = skid_data_q;

    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (deliver && skid_valid_q) begin
      head_valid_d  = 1'b1;
      head_bubble_d = skid_bubble_q;
      head_ctrl_d   = skid_ctrl_q;
      head_data_d   = skid_data_q;
      skid_valid_d  = accept;
      if (accept) begin
        skid_bubble_d = in_bubble;
        skid_ctrl_d   = in_ctrl_m;
        skid_data_d   = in_data;
      end
    end else if (deliver || !head_valid_q) begin
      head_valid_d = accept;
      if (accept) begin
        head_bubble_d = in_bubble;
        head_ctrl_d   = in_ctrl_m;
        head_data_d   = in_data;
      end
    end else if (accept && (SKID != 0)) begin
      skid_valid_d  = 1'b1;
      skid_bubble_d = in_bubble;
      skid_ctrl_d   = in_ctrl_m;
      skid_data_d   = in_data;
    end
  end

  // Counts deliveries regardless of flush, saturating at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (deliver && head_bubble_q && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_valid_q  <= 1'b0;
      head_bubble_q <= 1'b0;
      head_ctrl_q   <= '0;
      head_data_q   <= '0;
      skid_valid_q  <= 1'b0;
      skid_bubble_q <= 1'b0;
      skid_ctrl_q   <= '0;
      skid_data_q   <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      head_valid_q  <= head_valid_d;
      head_bubble_q <= head_bubble_d;
      head_ctrl_q   <= head_ctrl_d;
      head_data_q   <= head_data_d;
      skid_valid_q  <= skid_valid_d;
      skid_bubble_q <= skid_bubble_d;
      skid_ctrl_q   <= skid_ctrl_d;
      skid_data_q   <= skid_data_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign out_valid  = head_valid_q;
  assign out_bubble = head_valid_q && head_bubble_q;
  assign out_ctrl   = head_valid_q ? head_ctrl_q : '0;
  assign out_data   = head_data_q;
  assign occupancy  = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid stage (a), same stage with a 2-bit
// bubble counter sharing a's inputs (c), and a single-entry stage (b).
module tb_pipe_stage_reg;

  logic        clock;
  logic        reset;
  logic        flush;

  logic        a_in_valid, a_in_ready, a_in_bubble, a_out_valid, a_out_ready, a_out_bubble;
  logic [7:0]  a_in_ctrl, a_out_ctrl;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_cnt;

  logic        c_in_ready, c_out_valid, c_out_bubble;
  logic [7:0]  c_out_ctrl;
  logic [31:0] c_out_data;
  logic [1:0]  c_occ;
  logic [1:0]  c_cnt;

  logic        b_in_valid, b_in_ready, b_in_bubble, b_out_valid, b_out_ready, b_out_bubble;
  logic [7:0]  b_in_ctrl, b_out_ctrl;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_cnt;

  int n_cmp;
  int n_bad;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_bubble(a_in_bubble), .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bubble(a_out_bubble),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .bubble_cnt(a_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(c_in_ready),
    .in_bubble(a_in_bubble), .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(flush),
    .out_valid(c_out_valid), .out_ready(a_out_ready), .out_bubble(c_out_bubble),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data), .occupancy(c_occ), .bubble_cnt(c_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_bubble(b_in_bubble), .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bubble(b_out_bubble),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ), .bubble_cnt(b_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic bub, input logic [7:0] ctl, input logic [31:0] dat);
    a_in_valid  = v;
    a_in_bubble = bub;
    a_in_ctrl   = ctl;
    a_in_data   = dat;
  endtask

  task automatic b_drive(input logic v, input logic [31:0] dat);
    b_in_valid  = v;
    b_in_bubble = 1'b0;
    b_in_ctrl   = 8'h11;
    b_in_data   = dat;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    flush = 1'b0;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    a_drive(1'b0, 1'b0, 8'h00, 32'h0);
    b_drive(1'b0, 32'h0);
    #2;

    // reset state
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_data", a_out_data, 0);
    check("rst_a_ctrl", a_out_ctrl, 0);
    check("rst_a_occ", a_occ, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_a_ready", a_in_ready, 1);
    check("rst_b_ready", b_in_ready, 1);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_a_ready", a_in_ready, 1);
    check("post_rst_b_ready", b_in_ready, 1);

    // streaming 1,2,3 with out_ready=1
    a_out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_drive(1'b1, 1'b0, 8'h5A, i);
      tick();
      check("stream_data", a_out_data, i);
      check("stream_occ", a_occ, 1);
    end
    check("stream_ctrl", a_out_ctrl, 8'h5A);
    a_drive(1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    check("stream_drain_valid", a_out_valid, 0);
    check("stream_drain_ctrl", a_out_ctrl, 0);

    // backpressure fills the skid entry
    a_out_ready = 1'b0;
    a_drive(1'b1, 1'b0, 8'h01, 32'hA);
    tick();
    check("bp_occ1", a_occ, 1);
    check("bp_ready1", a_in_ready, 1);
    a_drive(1'b1, 1'b0, 8'h02, 32'hB);
    tick();
    a_drive(1'b0, 1'b0, 8'h00, 32'h0);
    check("bp_occ2", a_occ, 2);
    check("bp_ready_full", a_in_ready, 0);
    check("bp_head", a_out_data, 32'hA);
    tick();
    check("bp_hold_data", a_out_data, 32'hA);
    check("bp_hold_ctrl", a_out_ctrl, 8'h01);
    a_out_ready = 1'b1;
    #1;
    check("bp_no_comb_ready", a_in_ready, 0);
    tick();
    check("bp_second", a_out_data, 32'hB);
    check("bp_second_ctrl", a_out_ctrl, 8'h02);
    check("bp_occ_after", a_occ, 1);
    check("bp_ready_after", a_in_ready, 1);
    tick();
    check("bp_empty", a_out_valid, 0);

    // bubble entry
    a_out_ready = 1'b0;
    a_drive(1'b1, 1'b1, 8'hFF, 32'h1234);
    tick();
    a_drive(1'b0, 1'b0, 8'h00, 32'h0);
    check("bub_ctrl", a_out_ctrl, 8'h00);
    check("bub_flag", a_out_bubble, 1);
    check("bub_data", a_out_data, 32'h1234);
    check("bub_cnt0", a_cnt, 0);
    a_out_ready = 1'b1;
    tick();
    check("bub_cnt1", a_cnt, 1);
    check("bub_cnt1_c", c_cnt, 1);
    check("bub_gone", a_out_valid, 0);

    // saturation: fresh counters, five bubbles
    reset = 1'b1;
    #1;
    reset = 1'b0;
    a_drive(1'b1, 1'b1, 8'h33, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) a_drive(1'b0, 1'b0, 8'h00, 32'h0);
      if (i >= 2) begin
        check("sat_c_cnt", c_cnt, (i - 1 > 3) ? 3 : i - 1);
        check("wide_a_cnt", a_cnt, i - 1);
      end
    end

    // flush while full; a same-cycle accept is dropped
    a_out_ready = 1'b0;
    a_drive(1'b1, 1'b0, 8'h44, 32'hC1);
    tick();
    a_drive(1'b1, 1'b0, 8'h45, 32'hC2);
    tick();
    check("fl_full", a_occ, 2);
    flush = 1'b1;
    a_drive(1'b1, 1'b0, 8'h46, 32'hC3);
    tick();
    flush = 1'b0;
    a_drive(1'b0, 1'b0, 8'h00, 32'h0);
    check("fl_occ", a_occ, 0);
    check("fl_valid", a_out_valid, 0);
    check("fl_ready", a_in_ready, 1);
    check("fl_cnt", a_cnt, 5);
    check("fl_ctrl", a_out_ctrl, 0);

    // flush with a same-cycle bubble delivery still counts
    a_drive(1'b1, 1'b1, 8'h00, 32'h77);
    tick();
    a_out_ready = 1'b1;
    flush = 1'b1;
    a_drive(1'b1, 1'b0, 8'h12, 32'h78);
    tick();
    flush = 1'b0;
    a_drive(1'b0, 1'b0, 8'h00, 32'h0);
    check("fl_deliv_cnt", a_cnt, 6);
    check("fl_deliv_occ", a_occ, 0);

    // reset mid-transfer, then a normal accept
    a_out_ready = 1'b0;
    a_drive(1'b1, 1'b0, 8'h01, 32'hD1);
    tick();
    a_drive(1'b1, 1'b0, 8'h02, 32'hD2);
    tick();
    a_drive(1'b0, 1'b0, 8'h00, 32'h0);
    reset = 1'b1;
    #1;
    check("mid_rst_occ", a_occ, 0);
    check("mid_rst_data", a_out_data, 0);
    reset = 1'b0;
    a_drive(1'b1, 1'b0, 8'h03, 32'hE5);
    tick();
    a_drive(1'b0, 1'b0, 8'h00, 32'h0);
    check("after_rst_data", a_out_data, 32'hE5);
    check("after_rst_occ", a_occ, 1);

    // single-entry stage: ready follows out_ready combinationally
    b_out_ready = 1'b0;
    b_drive(1'b1, 32'h7);
    tick();
    b_drive(1'b0, 32'h0);
    #1;
    check("b_ready_full", b_in_ready, 0);
    check("b_data", b_out_data, 32'h7);
    check("b_ctrl", b_out_ctrl, 8'h11);
    b_out_ready = 1'b1;
    #1;
    check("b_ready_pass", b_in_ready, 1);
    b_drive(1'b1, 32'h8);
    tick();
    b_drive(1'b1, 32'h9);
    check("b_stream1", b_out_data, 32'h8);
    check("b_stream_occ", b_occ, 1);
    tick();
    b_drive(1'b0, 32'h0);
    check("b_stream2", b_out_data, 32'h9);
    b_out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("b_async_valid", b_out_valid, 0);
    check("b_async_occ", b_occ, 0);
    check("b_async_ready", b_in_ready, 1);
    #1;
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
